dm_stage: RTL and testbench
===========================

Name: dm_stage

Overview:
- Data-memory stage of the P6 five-stage pipeline, between the EX/MEM register and the MEM/WB register.
- Performs word, halfword and byte loads and stores on a word-organised synchronous-write RAM.
- Produces the extended load value that the MEM/WB register captures as DR.
- Clears itself word-by-word after reset, holding busy high to stall the pipeline, and latches the first alignment/range fault for debug.

Parameters:
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words (4 KiB by default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- mem_we  in  1  store request this cycle
- mem_re  in  1  load request this cycle
- mem_op  in  3  access type: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned, 5-7 reserved
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data; the low byte/half is used for narrow stores
- pc  in  32  PC of the instruction in MEM, for fault capture
- rdata  out  32  extended load data, combinational
- busy  out  1  clear sequence in progress; the pipeline must stall
- fault  out  1  sticky access-fault flag
- fault_addr  out  32  addr of the first faulting access
- fault_pc  out  32  pc of the first faulting access

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge): state<=CLEAR, clr_cnt<=0, fault<=0, fault_addr<=0, fault_pc<=0. Memory contents are untouched during reset itself.
- CLEAR state:
  - Each edge with rst_n=1 writes mem[clr_cnt]<=0 and increments clr_cnt.
  - At the edge where clr_cnt==DEPTH-1, state<=READY.
  - busy=1 throughout CLEAR, including while rst_n=0. busy drops exactly DEPTH edges after rst_n rises.
- Reset asserted mid-CLEAR: clr_cnt restarts at 0 and the full DEPTH-cycle sweep is repeated.
- READY state: terminal until the next reset. busy=0.
- Errors (combinational, err = mis | rng | bad_op):
  - Misaligned (mis): word access with addr[1:0]!=0, or half access with addr[0]!=0.
  - Out of range (rng): addr[31:ADDR_W+2]!=0.
  - Reserved op (bad_op): mem_op 5-7.
- Store:
  - Performed at the edge when mem_we=1, busy=0 and err=0.
  - Little-endian byte lanes. Word: all 4 bytes. Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0]. Byte: lane addr[1:0] gets wdata[7:0].
  - Unselected lanes of the word are preserved.
- Load: rdata is combinational from mem[addr[ADDR_W+1:2]].
  - Word: the full word.
  - Half: the selected half, sign- or zero-extended per mem_op.
  - Byte: the selected byte, sign- or zero-extended per mem_op.
  - rdata=0 when busy=1, mem_re=0, or err=1.
- Load and store to the same word in the same cycle: rdata shows the pre-store contents; the new value is visible from the next cycle.
- Fault capture:
  - At an edge with busy=0, (mem_we|mem_re)=1, err=1 and fault=0: fault<=1, fault_addr<=addr, fault_pc<=pc.
  - Later faults do not overwrite the captured values. Only reset clears them.
  - A faulting store does not modify memory.
- Requests while busy=1 are ignored: no write, rdata=0, no fault capture.

Test Plan:
- Clear sweep with ADDR_W=4: hold rst_n=0 for 2 edges, then release -> busy=1 for exactly 16 edges, then 0. Loads of all 16 words then return 0, including words preloaded with 0xFFFFFFFF before reset.
- Narrow stores: sw 0x11223344 @0x8; sb 0xAA @0xA; sh 0xBEEF @0x8 -> lw @0x8 returns 0x11AABEEF.
- Load extension with word 0x8001FF7F @0x10:
  - lb @0x10 -> 0x0000007F; lb @0x11 -> 0xFFFFFFFF
  - lbu @0x11 -> 0x000000FF; lh @0x12 -> 0xFFFF8001; lhu @0x12 -> 0x00008001
- Faults: sw @0x6 with pc=0x3010 -> fault=1, fault_addr=0x6, fault_pc=0x3010, memory unchanged. A later lh @0x1 keeps fault_addr=0x6. Access @0x00001000 with ADDR_W=10 flags a range fault after the fault register is cleared by reset.
- Reset mid-clear: assert rst_n=0 at clear cycle 5 for 1 edge -> busy stays 1 for a further full DEPTH edges; a sw issued during busy has no effect.
- Same-cycle load/store: mem_we=mem_re=1, sw 0xCAFEF00D @0x20 over old 0x12345678 -> rdata=0x12345678 that cycle; the next-cycle lw returns 0xCAFEF00D.

Source files
------------

// File: rtl/dm_stage.sv
// Data-memory stage: byte/half/word loads and stores on a word RAM with a
// post-reset clear sweep (busy stalls the pipeline) and first-fault capture.
module dm_stage #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fault_pc
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned BYTE_AW = ADDR_W + 2;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_HS = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_BS = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [31:0]       fault_addr_q, fault_addr_d;
  logic [31:0]       fault_pc_q, fault_pc_d;

  logic [ADDR_W-1:0] word_idx_c;
  logic [1:0]        lane_c;
  logic [31:0]       cur_word_c;
  logic              is_word_c, is_half_c;
  logic              mis_c, rng_c, bad_op_c, err_c;
  logic [15:0]       sel_half_c;
  logic [7:0]        sel_byte_c;
  logic [31:0]       st_word_c;
  logic              mem_wen_c;
  logic [ADDR_W-1:0] mem_widx_c;
  logic [31:0]       mem_wdat_c;

  // Address decode and access-error classification
  always_comb begin
    word_idx_c = addr[BYTE_AW-1:2];
    lane_c     = addr[1:0];
    cur_word_c = mem[word_idx_c];
    is_word_c  = (mem_op == OP_W);
    is_half_c  = (mem_op == OP_HS) || (mem_op == OP_HU);
    bad_op_c   = (mem_op > OP_BU);
    mis_c      = (is_word_c && (lane_c != 2'd0)) || (is_half_c && lane_c[0]);
    rng_c      = ((addr >> BYTE_AW) != 32'd0);
    err_c      = mis_c || rng_c || bad_op_c;
  end

  // Load lane selection and extension
  always_comb begin
    sel_half_c = lane_c[1] ? cur_word_c[31:16] : cur_word_c[15:0];
    case (lane_c)
      2'd0:    sel_byte_c = cur_word_c[7:0];
      2'd1:    sel_byte_c = cur_word_c[15:8];
      2'd2:    sel_byte_c = cur_word_c[23:16];
      default: sel_byte_c = cur_word_c[31:24];
    endcase
    rdata = 32'd0;
    if (!busy_q && mem_re && !err_c) begin
      case (mem_op)
        OP_W:    rdata = cur_word_c;
        OP_HS:   rdata = {{16{sel_half_c[15]}}, sel_half_c};
        OP_HU:   rdata = {16'd0, sel_half_c};
        OP_BS:   rdata = {{24{sel_byte_c[7]}}, sel_byte_c};
        OP_BU:   rdata = {24'd0, sel_byte_c};
        default: rdata = 32'd0;
      endcase
    end
  end

  // Store merge: narrow stores keep the unselected lanes of the current word
  always_comb begin
    st_word_c = cur_word_c;
    case (mem_op)
      OP_W: st_word_c = wdata;
      OP_HS, OP_HU: begin
        if (lane_c[1]) st_word_c[31:16] = wdata[15:0];
        else           st_word_c[15:0]  = wdata[15:0];
      end
      OP_BS, OP_BU: begin
        case (lane_c)
          2'd0:    st_word_c[7:0]   = wdata[7:0];
          2'd1:    st_word_c[15:8]  = wdata[7:0];
          2'd2:    st_word_c[23:16] = wdata[7:0];
          default: st_word_c[31:24] = wdata[7:0];
        endcase
      end
      default: st_word_c = cur_word_c;
    endcase
  end

  // Single write port shared by the clear sweep and pipeline stores
  always_comb begin
    mem_wen_c  = 1'b0;
    mem_widx_c = word_idx_c;
    mem_wdat_c = st_word_c;
    if (state_q == ST_CLEAR) begin
      mem_wen_c  = rst_n;
      mem_widx_c = clr_cnt_q;
      mem_wdat_c = 32'd0;
    end else if (mem_we && !err_c) begin
      mem_wen_c = rst_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wen_c) mem[mem_widx_c] <= mem_wdat_c;
  end

  // Next-state, clear counter and first-fault capture
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    busy_d       = busy_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_pc_d   = fault_pc_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
        end
      end
      ST_READY: busy_d = 1'b0;
      default:  state_d = ST_CLEAR;
    endcase
    if (!busy_q && (mem_we || mem_re) && err_c && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = addr;
      fault_pc_d   = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      busy_q       <= 1'b1;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
      fault_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  assign busy       = busy_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: a small (ADDR_W=4) instance for most checks and
// a default-size instance for the 4 KiB range boundary.
module tb_dm_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we, mem_re;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, pc;

  logic [31:0] rdata, fault_addr, fault_pc;
  logic        busy, fault;
  logic [31:0] rdata_w, fault_addr_w, fault_pc_w;
  logic        busy_w, fault_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_stage #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_re(mem_re), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .pc(pc), .rdata(rdata), .busy(busy),
    .fault(fault), .fault_addr(fault_addr), .fault_pc(fault_pc)
  );

  dm_stage #(.ADDR_W(10)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_we(mem_we), .mem_re(mem_re), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .pc(pc), .rdata(rdata_w), .busy(busy_w),
    .fault(fault_w), .fault_addr(fault_addr_w), .fault_pc(fault_pc_w)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic idle();
    mem_we = 1'b0; mem_re = 1'b0; mem_op = 3'd0;
    addr = 32'd0; wdata = 32'd0; pc = 32'd0;
  endtask

  // Drive one access for one cycle; rd/rd_w are sampled mid-cycle before the edge
  task automatic do_op(input logic we, input logic re, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                       output logic [31:0] rd, output logic [31:0] rd_w);
    mem_we = we; mem_re = re; mem_op = op; addr = a; wdata = wd; pc = p;
    #2;
    rd = rdata;
    rd_w = rdata_w;
    @(posedge clk); #1;
    idle();
  endtask

  // Count edges until busy falls; returns -1 past the bound
  task automatic wait_ready(input int bound, input bit wide, output int edges);
    edges = -1;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk); #1;
      if (!(wide ? busy_w : busy)) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] rd, rdw;
    int edges;

    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h08, 32'h11223344, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'd4, 32'h0A, 32'h000000AA, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'd2, 32'h08, 32'h0000BEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'd0, 32'h08, 32'h0,        32'h11AABEEF};
    vecs[4]  = '{1'b1, 1'b0, 3'd0, 32'h10, 32'h8001FF7F, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd3, 32'h10, 32'h0,        32'h0000007F};
    vecs[6]  = '{1'b0, 1'b1, 3'd3, 32'h11, 32'h0,        32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 1'b1, 3'd4, 32'h11, 32'h0,        32'h000000FF};
    vecs[8]  = '{1'b0, 1'b1, 3'd1, 32'h12, 32'h0,        32'hFFFF8001};
    vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h12, 32'h0,        32'h00008001};
    vecs[10] = '{1'b0, 1'b1, 3'd3, 32'h13, 32'h0,        32'hFFFFFF80};
    vecs[11] = '{1'b0, 1'b1, 3'd4, 32'h13, 32'h0,        32'h00000080};
    vecs[12] = '{1'b0, 1'b1, 3'd1, 32'h10, 32'h0,        32'hFFFFFF7F};
    vecs[13] = '{1'b0, 1'b1, 3'd2, 32'h10, 32'h0,        32'h0000FF7F};
    vecs[14] = '{1'b0, 1'b1, 3'd0, 32'h3C, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 1'b0, 3'd1, 32'h3E, 32'hFFFF1234, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 3'd3, 32'h3C, 32'h123456C3, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 3'd0, 32'h3C, 32'h0,        32'h123400C3};
    vecs[18] = '{1'b0, 1'b0, 3'd0, 32'h10, 32'h0,        32'h0};
    vecs[19] = '{1'b0, 1'b1, 3'd0, 32'h10, 32'h0,        32'h8001FF7F};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(100, 1'b0, edges);
    check("first_clear_done", 32'(edges), 32'd16);

    // Preload every word with ones so the second sweep has something to clear
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 3'd0, 32'(i * 4), 32'hFFFFFFFF, 32'd0, rd, rdw);
    do_op(1'b0, 1'b1, 3'd0, 32'h04, 32'd0, 32'd0, rd, rdw);
    check("preload_lw", rd, 32'hFFFFFFFF);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    do_op(1'b0, 1'b1, 3'd0, 32'h04, 32'd0, 32'd0, rd, rdw);
    check("rst_rdata_zero", rd, 32'd0);
    check("rst_mem_kept_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    wait_ready(100, 1'b0, edges);
    check("clear_busy_edges", 32'(edges), 32'd16);
    for (int i = 0; i < 16; i++) begin
      do_op(1'b0, 1'b1, 3'd0, 32'(i * 4), 32'd0, 32'd0, rd, rdw);
      check($sformatf("cleared_w%0d", i), rd, 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].we, vecs[i].re, vecs[i].op, vecs[i].a, vecs[i].wd, 32'd0, rd, rdw);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    check("no_fault_yet", 32'(fault), 32'd0);

    // Misaligned store is captured and does not touch memory
    do_op(1'b1, 1'b0, 3'd0, 32'h06, 32'hDEADBEEF, 32'h3010, rd, rdw);
    check("flt_set", 32'(fault), 32'd1);
    check("flt_addr", fault_addr, 32'h6);
    check("flt_pc", fault_pc, 32'h3010);
    do_op(1'b0, 1'b1, 3'd0, 32'h04, 32'd0, 32'd0, rd, rdw);
    check("flt_mem_unchanged", rd, 32'd0);
    do_op(1'b0, 1'b1, 3'd1, 32'h01, 32'd0, 32'h3020, rd, rdw);
    check("flt_lh_rdata", rd, 32'd0);
    check("flt_sticky_addr", fault_addr, 32'h6);
    check("flt_sticky_pc", fault_pc, 32'h3010);
    do_op(1'b0, 1'b1, 3'd5, 32'h10, 32'd0, 32'd0, rd, rdw);
    check("bad_op_rdata", rd, 32'd0);

    // Reset again, then a one-edge reset at clear cycle 5 restarts the sweep
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("flt_cleared", 32'(fault), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_busy", 32'(busy), 32'd1);
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      idle();
      if (k == 2) begin
        mem_re = 1'b1; addr = 32'h3C;
        #1;
        check("busy_load_zero", rdata, 32'd0);
      end else if (k == 4) begin
        mem_re = 1'b1; addr = 32'h02; pc = 32'h5000;
      end else if (k == 10) begin
        mem_we = 1'b1; addr = 32'h08; wdata = 32'h55555555;
      end
      @(posedge clk); #1;
      if (!busy) begin
        edges = k;
        break;
      end
    end
    idle();
    check("mid_restart_edges", 32'(edges), 32'd16);
    check("busy_no_fault", 32'(fault), 32'd0);
    do_op(1'b0, 1'b1, 3'd0, 32'h08, 32'd0, 32'd0, rd, rdw);
    check("busy_store_ignored", rd, 32'd0);
    do_op(1'b0, 1'b1, 3'd0, 32'h3C, 32'd0, 32'd0, rd, rdw);
    check("mid_swept_last", rd, 32'd0);

    // Same-cycle load and store returns the old word
    do_op(1'b1, 1'b0, 3'd0, 32'h20, 32'h12345678, 32'd0, rd, rdw);
    do_op(1'b1, 1'b1, 3'd0, 32'h20, 32'hCAFEF00D, 32'd0, rd, rdw);
    check("rw_same_old", rd, 32'h12345678);
    do_op(1'b0, 1'b1, 3'd0, 32'h20, 32'd0, 32'd0, rd, rdw);
    check("rw_next_new", rd, 32'hCAFEF00D);

    // 4 KiB range boundary on the default-size instance
    wait_ready(2000, 1'b1, edges);
    check("wide_ready", 32'(edges > 0), 32'd1);
    check("wide_no_fault", 32'(fault_w), 32'd0);
    do_op(1'b0, 1'b1, 3'd0, 32'h0FFC, 32'd0, 32'h4000, rd, rdw);
    check("wide_last_word", rdw, 32'd0);
    check("wide_last_no_fault", 32'(fault_w), 32'd0);
    check("small_range_addr", fault_addr, 32'h0FFC);
    do_op(1'b0, 1'b1, 3'd0, 32'h1000, 32'd0, 32'h4004, rd, rdw);
    check("wide_range_rdata", rdw, 32'd0);
    check("wide_range_fault", 32'(fault_w), 32'd1);
    check("wide_range_addr", fault_addr_w, 32'h1000);
    check("wide_range_pc", fault_pc_w, 32'h4004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
